// File: rtl/pipe_reg2_elastic.sv
// Decode->execute pipeline register with a 2-entry skid buffer on a valid/ready
// boundary, flush, bubble-gated side-effect controls and a saturating stall counter.
module pipe_reg2_elastic #(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int ALU_CTRL_WIDTH   = 3,
  parameter int RESULT_SRC_WIDTH = 2,
  parameter int STALL_CNT_WIDTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        validD_i,
  output logic                        readyD_o,
  input  logic                        flush_i,
  input  logic [ADDRESS_WIDTH-1:0]    rd1D_i,
  input  logic [ADDRESS_WIDTH-1:0]    rd2D_i,
  input  logic [ADDRESS_WIDTH-1:0]    pcD_i,
  input  logic [ADDRESS_WIDTH-1:0]    pc_plus4D_i,
  input  logic [DATA_WIDTH-1:0]       imm_extD_i,
  input  logic [4:0]                  rdD_i,
  input  logic [4:0]                  rs1D_i,
  input  logic [4:0]                  rs2D_i,
  input  logic                        reg_writeD_i,
  input  logic                        mem_writeD_i,
  input  logic                        jumpD_i,
  input  logic                        branchD_i,
  input  logic                        alu_srcD_i,
  input  logic [RESULT_SRC_WIDTH-1:0] result_srcD_i,
  input  logic [ALU_CTRL_WIDTH-1:0]   alu_ctrlD_i,
  output logic [ADDRESS_WIDTH-1:0]    rd1E_o,
  output logic [ADDRESS_WIDTH-1:0]    rd2E_o,
  output logic [ADDRESS_WIDTH-1:0]    pcE_o,
  output logic [ADDRESS_WIDTH-1:0]    pc_plus4E_o,
  output logic [DATA_WIDTH-1:0]       imm_extE_o,
  output logic [4:0]                  rdE_o,
  output logic [4:0]                  rs1E_o,
  output logic [4:0]                  rs2E_o,
  output logic                        reg_writeE_o,
  output logic                        mem_writeE_o,
  output logic                        jumpE_o,
  output logic                        branchE_o,
  output logic                        alu_srcE_o,
  output logic [RESULT_SRC_WIDTH-1:0] result_srcE_o,
  output logic [ALU_CTRL_WIDTH-1:0]   alu_ctrlE_o,
  output logic                        validE_o,
  input  logic                        readyE_i,
  output logic [1:0]                  occE_o,
  output logic [STALL_CNT_WIDTH-1:0]  stall_cntE_o
);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0]    rd1;
    logic [ADDRESS_WIDTH-1:0]    rd2;
    logic [ADDRESS_WIDTH-1:0]    pc;
    logic [ADDRESS_WIDTH-1:0]    pc_plus4;
    logic [DATA_WIDTH-1:0]       imm_ext;
    logic [4:0]                  rd;
    logic [4:0]                  rs1;
    logic [4:0]                  rs2;
    logic                        reg_write;
    logic                        mem_write;
    logic                        jump;
    logic                        branch;
    logic                        alu_src;
    logic [RESULT_SRC_WIDTH-1:0] result_src;
    logic [ALU_CTRL_WIDTH-1:0]   alu_ctrl;
  } payload_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t                     state_reg;
  payload_t                   main_reg;
  payload_t                   skid_reg;
  logic                       ready_reg;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_reg;
  payload_t                   in_payload;
  logic                       main_valid;
  logic                       accept;
  logic                       retire;

  assign in_payload = '{rd1: rd1D_i, rd2: rd2D_i, pc: pcD_i, pc_plus4: pc_plus4D_i,
                        imm_ext: imm_extD_i, rd: rdD_i, rs1: rs1D_i, rs2: rs2D_i,
                        reg_write: reg_writeD_i, mem_write: mem_writeD_i,
                        jump: jumpD_i, branch: branchD_i, alu_src: alu_srcD_i,
                        result_src: result_srcD_i, alu_ctrl: alu_ctrlD_i};

  assign main_valid = (state_reg != EMPTY);
  assign accept     = validD_i & ready_reg;
  assign retire     = main_valid & readyE_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= EMPTY;
      main_reg      <= '0;
      skid_reg      <= '0;
      ready_reg     <= 1'b1;
      stall_cnt_reg <= '0;
    end else begin
      if (main_valid && !readyE_i && !(&stall_cnt_reg))
        stall_cnt_reg <= stall_cnt_reg + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
      // Flush only drops valid state; stale payload stays visible behind gated controls.
      if (flush_i) begin
        state_reg <= EMPTY;
        ready_reg <= 1'b1;
      end else begin
        case (state_reg)
          EMPTY: begin
            if (accept) begin
              main_reg  <= in_payload;
              state_reg <= ONE;
            end
          end
          ONE: begin
            if (accept && retire) begin
              main_reg <= in_payload;
            end else if (accept) begin
              skid_reg  <= in_payload;
              state_reg <= TWO;
              ready_reg <= 1'b0;
            end else if (retire) begin
              state_reg <= EMPTY;
            end
          end
          TWO: begin
            if (retire) begin
              main_reg  <= skid_reg;
              skid_reg  <= '0;
              state_reg <= ONE;
              ready_reg <= 1'b1;
            end
          end
          default: begin
            state_reg <= EMPTY;
            ready_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign readyD_o      = ready_reg;
  assign validE_o      = main_valid;
  assign occE_o        = {state_reg == TWO, state_reg == ONE};
  assign stall_cntE_o  = stall_cnt_reg;

  assign rd1E_o        = main_reg.rd1;
  assign rd2E_o        = main_reg.rd2;
  assign pcE_o         = main_reg.pc;
  assign pc_plus4E_o   = main_reg.pc_plus4;
  assign imm_extE_o    = main_reg.imm_ext;
  assign rdE_o         = main_reg.rd;
  assign rs1E_o        = main_reg.rs1;
  assign rs2E_o        = main_reg.rs2;
  assign alu_srcE_o    = main_reg.alu_src;
  assign result_srcE_o = main_reg.result_src;
  assign alu_ctrlE_o   = main_reg.alu_ctrl;
  assign reg_writeE_o  = main_reg.reg_write & main_valid;
  assign mem_writeE_o  = main_reg.mem_write & main_valid;
  assign jumpE_o       = main_reg.jump & main_valid;
  assign branchE_o     = main_reg.branch & main_valid;

endmodule

// File: tb/tb_pipe_reg2_elastic.sv
// Directed bench: default-parameter instance plus a narrow-counter / 4-bit ALU
// instance sharing the same stimulus.
module tb_pipe_reg2_elastic;

  logic        clk_i = 1'b0;
  logic        rst_i, validD_i, flush_i, readyE_i;
  logic [31:0] rd1D_i, rd2D_i, pcD_i, pc_plus4D_i, imm_extD_i;
  logic [4:0]  rdD_i, rs1D_i, rs2D_i;
  logic        reg_writeD_i, mem_writeD_i, jumpD_i, branchD_i, alu_srcD_i;
  logic [1:0]  result_srcD_i;
  logic [3:0]  alu_ctrlD_i;

  logic        readyD_o, validE_o;
  logic [31:0] rd1E_o, rd2E_o, pcE_o, pc_plus4E_o, imm_extE_o;
  logic [4:0]  rdE_o, rs1E_o, rs2E_o;
  logic        reg_writeE_o, mem_writeE_o, jumpE_o, branchE_o, alu_srcE_o;
  logic [1:0]  result_srcE_o, occE_o;
  logic [2:0]  alu_ctrlE_o;
  logic [15:0] stall_cntE_o;

  logic        readyD_w, validE_w;
  logic [31:0] rd1E_w, rd2E_w, pcE_w, pc_plus4E_w, imm_extE_w;
  logic [4:0]  rdE_w, rs1E_w, rs2E_w;
  logic        reg_writeE_w, mem_writeE_w, jumpE_w, branchE_w, alu_srcE_w;
  logic [1:0]  result_srcE_w, occE_w;
  logic [3:0]  alu_ctrlE_w;
  logic [2:0]  stall_cntE_w;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  pipe_reg2_elastic u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .validD_i(validD_i), .readyD_o(readyD_o), .flush_i(flush_i),
    .rd1D_i(rd1D_i), .rd2D_i(rd2D_i), .pcD_i(pcD_i), .pc_plus4D_i(pc_plus4D_i),
    .imm_extD_i(imm_extD_i), .rdD_i(rdD_i), .rs1D_i(rs1D_i), .rs2D_i(rs2D_i),
    .reg_writeD_i(reg_writeD_i), .mem_writeD_i(mem_writeD_i), .jumpD_i(jumpD_i),
    .branchD_i(branchD_i), .alu_srcD_i(alu_srcD_i), .result_srcD_i(result_srcD_i),
    .alu_ctrlD_i(alu_ctrlD_i[2:0]),
    .rd1E_o(rd1E_o), .rd2E_o(rd2E_o), .pcE_o(pcE_o), .pc_plus4E_o(pc_plus4E_o),
    .imm_extE_o(imm_extE_o), .rdE_o(rdE_o), .rs1E_o(rs1E_o), .rs2E_o(rs2E_o),
    .reg_writeE_o(reg_writeE_o), .mem_writeE_o(mem_writeE_o), .jumpE_o(jumpE_o),
    .branchE_o(branchE_o), .alu_srcE_o(alu_srcE_o), .result_srcE_o(result_srcE_o),
    .alu_ctrlE_o(alu_ctrlE_o), .validE_o(validE_o), .readyE_i(readyE_i),
    .occE_o(occE_o), .stall_cntE_o(stall_cntE_o)
  );

  pipe_reg2_elastic #(.ALU_CTRL_WIDTH(4), .STALL_CNT_WIDTH(3)) u_dut_w (
    .clk_i(clk_i), .rst_i(rst_i), .validD_i(validD_i), .readyD_o(readyD_w), .flush_i(flush_i),
    .rd1D_i(rd1D_i), .rd2D_i(rd2D_i), .pcD_i(pcD_i), .pc_plus4D_i(pc_plus4D_i),
    .imm_extD_i(imm_extD_i), .rdD_i(rdD_i), .rs1D_i(rs1D_i), .rs2D_i(rs2D_i),
    .reg_writeD_i(reg_writeD_i), .mem_writeD_i(mem_writeD_i), .jumpD_i(jumpD_i),
    .branchD_i(branchD_i), .alu_srcD_i(alu_srcD_i), .result_srcD_i(result_srcD_i),
    .alu_ctrlD_i(alu_ctrlD_i),
    .rd1E_o(rd1E_w), .rd2E_o(rd2E_w), .pcE_o(pcE_w), .pc_plus4E_o(pc_plus4E_w),
    .imm_extE_o(imm_extE_w), .rdE_o(rdE_w), .rs1E_o(rs1E_w), .rs2E_o(rs2E_w),
    .reg_writeE_o(reg_writeE_w), .mem_writeE_o(mem_writeE_w), .jumpE_o(jumpE_w),
    .branchE_o(branchE_w), .alu_srcE_o(alu_srcE_w), .result_srcE_o(result_srcE_w),
    .alu_ctrlE_o(alu_ctrlE_w), .validE_o(validE_w), .readyE_i(readyE_i),
    .occE_o(occE_w), .stall_cntE_o(stall_cntE_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; validD_i = 1'b0; flush_i = 1'b0; readyE_i = 1'b1;
    rd1D_i = 32'h0; rd2D_i = 32'h0; pcD_i = 32'h0; pc_plus4D_i = 32'h0; imm_extD_i = 32'h0;
    rdD_i = 5'd0; rs1D_i = 5'd0; rs2D_i = 5'd0;
    reg_writeD_i = 1'b0; mem_writeD_i = 1'b0; jumpD_i = 1'b0; branchD_i = 1'b0;
    alu_srcD_i = 1'b0; result_srcD_i = 2'd0; alu_ctrlD_i = 4'd0;
    step();
    check("rst_valid", validE_o, 0);
    check("rst_occ", occE_o, 0);
    check("rst_ready", readyD_o, 1);
    check("rst_stall", stall_cntE_o, 0);
    check("rst_stall_w", stall_cntE_w, 0);
    rst_i = 1'b0;

    // Full-throughput streaming
    validD_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pcD_i = 32'(i * 4);
      pc_plus4D_i = 32'(i * 4 + 4);
      step();
      check($sformatf("stream_pc%0d", i), pcE_o, 64'(i * 4));
      check($sformatf("stream_pc4_%0d", i), pc_plus4E_o, 64'(i * 4 + 4));
      check($sformatf("stream_valid%0d", i), validE_o, 1);
      check($sformatf("stream_occ%0d", i), occE_o, 1);
      check($sformatf("stream_ready%0d", i), readyD_o, 1);
    end
    validD_i = 1'b0;
    step();
    check("drain_valid", validE_o, 0);
    check("drain_occ", occE_o, 0);

    // Fill the skid buffer under back-pressure, then drain in order
    readyE_i = 1'b0; validD_i = 1'b1; pcD_i = 32'h10;
    step();
    check("skid_occ1", occE_o, 1);
    pcD_i = 32'h14;
    step();
    check("skid_occ2", occE_o, 2);
    check("skid_ready", readyD_o, 0);
    check("skid_pc_hold", pcE_o, 32'h10);
    pcD_i = 32'h18;
    step();
    check("skid_no_accept_occ", occE_o, 2);
    check("skid_pc_hold2", pcE_o, 32'h10);
    validD_i = 1'b0; readyE_i = 1'b1;
    step();
    check("skid_drain_pc", pcE_o, 32'h14);
    check("skid_drain_occ", occE_o, 1);
    check("skid_drain_ready", readyD_o, 1);
    step();
    check("skid_empty_valid", validE_o, 0);
    check("stall_after_skid", stall_cntE_o, 2);

    // Flush with two held entries and an incoming instruction
    readyE_i = 1'b0; validD_i = 1'b1; reg_writeD_i = 1'b1; mem_writeD_i = 1'b1; pcD_i = 32'h20;
    step();
    check("fl_regw_live", reg_writeE_o, 1);
    pcD_i = 32'h24;
    step();
    check("fl_occ2", occE_o, 2);
    flush_i = 1'b1; pcD_i = 32'h28;
    step();
    check("fl_valid", validE_o, 0);
    check("fl_occ", occE_o, 0);
    check("fl_regw", reg_writeE_o, 0);
    check("fl_memw", mem_writeE_o, 0);
    check("fl_ready", readyD_o, 1);
    check("fl_stall_kept", stall_cntE_o, 4);
    flush_i = 1'b0; validD_i = 1'b0; reg_writeD_i = 1'b0; mem_writeD_i = 1'b0;
    step();
    check("fl_drop_incoming", validE_o, 0);

    // Stall counter and saturation
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; validD_i = 1'b1; pcD_i = 32'h30;
    step();
    validD_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("stall5", stall_cntE_o, 5);
    check("stall5_w", stall_cntE_w, 5);
    for (int i = 0; i < 5; i++) step();
    check("stall10", stall_cntE_o, 10);
    check("stall_sat_w", stall_cntE_w, 7);

    // Reset beats flush and handshake mid-stall
    validD_i = 1'b1; pcD_i = 32'h34; rd1D_i = 32'hCAFE; imm_extD_i = 32'h55; rdD_i = 5'd9;
    step();
    check("pre_rst_occ", occE_o, 2);
    rst_i = 1'b1; flush_i = 1'b1;
    step();
    check("rr_valid", validE_o, 0);
    check("rr_occ", occE_o, 0);
    check("rr_ready", readyD_o, 1);
    check("rr_pc", pcE_o, 0);
    check("rr_rd1", rd1E_o, 0);
    check("rr_imm", imm_extE_o, 0);
    check("rr_rd", rdE_o, 0);
    check("rr_stall", stall_cntE_o, 0);
    rst_i = 1'b0; flush_i = 1'b0; validD_i = 1'b0;
    step();
    check("rr_after_valid", validE_o, 0);

    // Wide ALU control and register-address payload
    readyE_i = 1'b1; validD_i = 1'b1; alu_ctrlD_i = 4'hA; rs1D_i = 5'd5; rs2D_i = 5'd31;
    rd1D_i = 32'hDEADBEEF; rd2D_i = 32'h0BADF00D; imm_extD_i = 32'h12345678; rdD_i = 5'd7;
    pcD_i = 32'h40; jumpD_i = 1'b1; branchD_i = 1'b1; alu_srcD_i = 1'b1; result_srcD_i = 2'd3;
    step();
    check("alu_w", alu_ctrlE_w, 4'hA);
    check("alu_narrow", alu_ctrlE_o, 3'h2);
    check("rs1_w", rs1E_w, 5);
    check("rs2_w", rs2E_w, 31);
    check("rd1", rd1E_o, 32'hDEADBEEF);
    check("rd2", rd2E_o, 32'h0BADF00D);
    check("imm", imm_extE_o, 32'h12345678);
    check("rd", rdE_o, 7);
    check("jump_live", jumpE_o, 1);
    check("branch_live", branchE_o, 1);
    check("alu_src", alu_srcE_o, 1);
    check("result_src", result_srcE_o, 3);
    validD_i = 1'b0;
    step();
    check("bubble_jump", jumpE_o, 0);
    check("bubble_branch", branchE_o, 0);
    check("bubble_pc_hold", pcE_o, 32'h40);
    check("bubble_alu_hold", alu_ctrlE_w, 4'hA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_reg2_elastic.md
Name: pipe_reg2_elastic

Overview:
Parametrised successor to the decode->execute pipeline register. It carries the full decode payload (operands, PC values, immediate, destination and source register addresses, control word) across a valid/ready elastic boundary with a 2-entry skid buffer. This gives stall support from execute and flush support from branch/jump resolution. It also gates side-effecting control bits on bubbles and counts back-pressure cycles for performance analysis.

Parameters:
ADDRESS_WIDTH, 32, width of PC, PC+4 and register read data
DATA_WIDTH, 32, width of extended immediate
ALU_CTRL_WIDTH, 3, width of ALU control field (widened to 4 when the ALU grows)
RESULT_SRC_WIDTH, 2, width of result-select field
STALL_CNT_WIDTH, 16, width of saturating stall counter

Ports:
clk_i  in  1  clock, all state on posedge
rst_i  in  1  synchronous, active-high reset
validD_i  in  1  decode presents a valid instruction
readyD_o  out  1  register can accept (registered, = skid entry empty)
flush_i  in  1  kill all held and incoming instructions
rd1D_i, rd2D_i / rd1E_o, rd2E_o  in/out  ADDRESS_WIDTH  register read data
pcD_i, pc_plus4D_i / pcE_o, pc_plus4E_o  in/out  ADDRESS_WIDTH  PC, PC+4
imm_extD_i / imm_extE_o  in/out  DATA_WIDTH  extended immediate
rdD_i, rs1D_i, rs2D_i / rdE_o, rs1E_o, rs2E_o  in/out  5  dest/source register addresses
reg_writeD_i, mem_writeD_i, jumpD_i, branchD_i, alu_srcD_i / *E_o  in/out  1 each  control bits
result_srcD_i / result_srcE_o  in/out  RESULT_SRC_WIDTH  result select
alu_ctrlD_i / alu_ctrlE_o  in/out  ALU_CTRL_WIDTH  ALU operation
validE_o  out  1  execute-side payload valid
readyE_i  in  1  execute accepts current payload
occE_o  out  2  entries held (0..2)
stall_cntE_o  out  STALL_CNT_WIDTH  cycles with validE_o=1 and readyE_i=0

Behaviour:
- Storage: main entry (drives outputs) and skid entry. Each entry holds the full payload plus a valid bit.
- Handshakes: accept = validD_i & readyD_o; retire = validE_o & readyE_i.
- readyD_o = !skid_valid. It is registered and has no combinational path from readyE_i.
- validE_o = main_valid. occE_o = main_valid + skid_valid.
- States and transitions:
  - EMPTY: on accept -> ONE (main <= input).
  - ONE: accept & retire -> ONE (main <= input). accept only -> TWO (skid <= input). retire only -> EMPTY. Neither -> hold.
  - TWO: retire -> ONE (main <= skid, skid cleared). No accept is possible while in TWO.
- Latency: 1 cycle from accept to validE_o. Full throughput (1/cycle) while readyE_i=1. Order is always preserved.
- Payload is stable while validE_o=1 and readyE_i=0.
- Bubble gating: reg_writeE_o, mem_writeE_o, jumpE_o and branchE_o are the stored bits ANDed with main_valid. All other outputs show the last main payload when empty.
- flush_i: next cycle is EMPTY and readyD_o=1. An input offered in the flush cycle is discarded. Retire in the flush cycle is still reported to execute; consumers qualify it with their own flush.
- rst_i: has priority over flush_i and all handshakes. Next cycle: every payload output and stall_cntE_o = 0, validE_o = 0, occE_o = 0, readyD_o = 1. Reset mid-stall drops held entries.
- stall_cntE_o increments when validE_o & !readyE_i and saturates at all-ones (no wrap). It is not cleared by flush_i.

Test Plan:
- Reset, then validD_i=1 streaming pc 0x0,0x4,0x8 with readyE_i=1 -> pcE_o 0x0,0x4,0x8 one cycle later each, validE_o=1, occE_o=1, readyD_o stays 1.
- Load pc 0x10 then 0x14 with readyE_i=0 -> occE_o=2, readyD_o=0, pcE_o holds 0x10. Raise readyE_i -> pcE_o 0x10 then 0x14, no loss or duplication.
- Occupancy 2 with reg_writeD=1, mem_writeD=1; assert flush_i with validD_i=1 -> next cycle validE_o=0, occE_o=0, reg_writeE_o=0, mem_writeE_o=0, readyD_o=1.
- Hold validE_o=1, readyE_i=0 for 5 cycles -> stall_cntE_o=5. With STALL_CNT_WIDTH=3, hold for 10 cycles -> stall_cntE_o saturates at 7.
- During a held stall (occE_o=2) assert rst_i together with flush_i and validD_i -> next cycle all outputs 0, readyD_o=1, validE_o=0.
- ALU_CTRL_WIDTH=4, alu_ctrlD_i=4'hA, rs1D_i=5, rs2D_i=31 -> alu_ctrlE_o=4'hA, rs1E_o=5, rs2E_o=31 one cycle after accept.
